cla_chain_sequencer: RTL and testbench
======================================

CLA_CHAIN_SEQUENCER -- requirements
Module: cla_chain_sequencer

Interface
REQ-001 Parameter WIDTH, default 7, SHALL set the word width of the sequenced carry_look_ahead datapath.
REQ-002 Parameter MAX_WORDS, default 4, SHALL set the maximum number of words in one chained addition (range 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 start  input  1  SHALL begin a chained addition when sampled high in IDLE.
REQ-006 carry_in  input  1  SHALL be the initial carry, sampled with start.
REQ-007 abort  input  1  SHALL cancel an operation in progress.
REQ-008 in_valid  input  1  SHALL qualify a_in, b_in and in_last.
REQ-009 a_in, b_in  input  WIDTH each  SHALL be the operand words, least significant word first.
REQ-010 in_last  input  1  SHALL mark the final word of the operation.
REQ-011 in_ready  output  1  SHALL indicate that the word on a_in/b_in is accepted this cycle.
REQ-012 cla_a, cla_b  output  WIDTH each  SHALL drive the external carry_look_ahead operand ports from registers.
REQ-013 cla_y  output  1  SHALL drive the carry_look_ahead carry input from the chain-carry register.
REQ-014 cla_s  input  WIDTH and cla_c  input  1  SHALL be the carry_look_ahead sum and carry-out.
REQ-015 s_out  output  WIDTH, s_valid  output  1  SHALL present each result word for exactly one cycle.
REQ-016 c_out  output  1, done  output  1  SHALL present the final carry with a one-cycle done pulse.
REQ-017 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_IN, EXEC, FINISH.
REQ-019 IDLE: in_ready=0; on start=1, chain carry SHALL load carry_in, word count SHALL clear to 0, next state WAIT_IN.
REQ-020 WAIT_IN: in_ready=1; on in_valid=1 the word SHALL be accepted into cla_a/cla_b, word count SHALL increment, last flag SHALL be recorded, next state EXEC.
REQ-021 EXEC: in_ready=0; at the ending edge s_out SHALL capture cla_s, s_valid SHALL be high for the following cycle only, chain carry SHALL capture cla_c.
REQ-022 EXEC SHALL go to FINISH if the recorded last flag is set or word count equals MAX_WORDS, else to WAIT_IN.
REQ-023 FINISH: c_out SHALL hold the chain carry, done SHALL be high for this one cycle, next state IDLE.
REQ-024 Latency: word accepted at edge k SHALL yield s_valid after edge k+1; throughput one word per two cycles.
REQ-025 The word at count MAX_WORDS SHALL be treated as last regardless of in_last; count SHALL never wrap.
REQ-026 s_out and c_out SHALL hold their last value until next updated; only s_valid and done pulse.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with no s_valid or done pulse; abort SHALL take priority over in_valid and the EXEC update.
REQ-029 abort together with start in IDLE SHALL leave the block in IDLE.
REQ-030 WIDTH-bit sums SHALL be modulo 2^WIDTH, the overflow bit propagating only through the chain carry.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, in_ready=0, s_valid=0, done=0, busy=0, s_out=0, c_out=0, cla_a=0, cla_b=0, chain carry=0, word count=0.
REQ-032 Reset mid-operation SHALL discard all partial results with no further s_valid or done pulse.

Verification
REQ-033 start, carry_in=0; words (127,1,last=0),(0,0,last=1) -> s_out 0 then 1, c_out=0, done one cycle after the second s_valid.
REQ-034 start, carry_in=1; one word (127,127,last=1) -> s_out=127, c_out=1, done pulse, busy low next cycle.
REQ-035 MAX_WORDS=4, five words (127,0) with in_last=0, carry_in=1 -> four s_out=0, done after fourth, c_out=1, fifth word not accepted (in_ready=0).
REQ-036 abort asserted during EXEC of word 2 -> no s_valid for word 2, no done, IDLE next cycle; new start works normally.
REQ-037 rst_n=0 during WAIT_IN after one word -> all outputs at reset values next cycle; start during busy ignored.
REQ-038 in_valid held low for 10 cycles in WAIT_IN -> in_ready stays high, no output change.

Source files
------------

// File: rtl/cla_chain_sequencer_if.sv
// Bundle between the chain sequencer, its host and the external
// carry_look_ahead adder. The slave side is the sequencer itself.
interface cla_chain_sequencer_if #(
  parameter int WIDTH = 7
);
  // host -> sequencer
  logic             start;
  logic             carry_in;
  logic             abort;
  logic             in_valid;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             in_last;
  // sequencer -> host
  logic             in_ready;
  logic [WIDTH-1:0] s_out;
  logic             s_valid;
  logic             c_out;
  logic             done;
  logic             busy;
  // sequencer <-> carry_look_ahead
  logic [WIDTH-1:0] cla_a;
  logic [WIDTH-1:0] cla_b;
  logic             cla_y;
  logic [WIDTH-1:0] cla_s;
  logic             cla_c;

  modport slave (
    input  start, carry_in, abort, in_valid, a_in, b_in, in_last, cla_s, cla_c,
    output in_ready, s_out, s_valid, c_out, done, busy, cla_a, cla_b, cla_y
  );

  modport master (
    output start, carry_in, abort, in_valid, a_in, b_in, in_last, cla_s, cla_c,
    input  in_ready, s_out, s_valid, c_out, done, busy, cla_a, cla_b, cla_y
  );
endinterface

// File: rtl/cla_chain_sequencer.sv
// Multi-word adder sequencer: feeds one operand word pair per two cycles
// to an external carry_look_ahead block, chaining its carry-out back into
// its carry-in, and streams out the sum words plus the final carry.
module cla_chain_sequencer #(
  parameter int WIDTH     = 7,
  parameter int MAX_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cla_chain_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WAIT_IN, EXEC, FINISH} state_t;

  // 4-bit count covers MAX_WORDS up to 15, so it can never wrap
  localparam logic [3:0] MAXW = 4'(MAX_WORDS);

  state_t           state, state_nx;
  logic [3:0]       cnt;
  logic             last_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             s_vld_q, c_q;
  logic             end_chain;

  // word at the count limit closes the chain even without in_last
  assign end_chain = last_q || (cnt == MAXW);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and handshake outputs; abort overrides everything when busy
  always_comb begin
    state_nx    = state;
    bus.in_ready = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = (state != IDLE);
    case (state)
      IDLE:    if (bus.start && !bus.abort) state_nx = WAIT_IN;
      WAIT_IN: begin
        bus.in_ready = !bus.abort;
        if (bus.abort)         state_nx = IDLE;
        else if (bus.in_valid) state_nx = EXEC;
      end
      EXEC:    begin
        if (bus.abort)      state_nx = IDLE;
        else if (end_chain) state_nx = FINISH;
        else                state_nx = WAIT_IN;
      end
      FINISH:  begin
        bus.done = !bus.abort;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath: operand capture, result capture and chain carry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      last_q  <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      s_vld_q <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      s_vld_q <= 1'b0;
      case (state)
        IDLE: if (bus.start && !bus.abort) begin
          carry_q <= bus.carry_in;
          cnt     <= '0;
        end
        WAIT_IN: if (bus.in_valid && !bus.abort) begin
          a_q    <= bus.a_in;
          b_q    <= bus.b_in;
          last_q <= bus.in_last;
          cnt    <= cnt + 4'd1;
        end
        EXEC: if (!bus.abort) begin
          s_q     <= bus.cla_s;
          s_vld_q <= 1'b1;
          carry_q <= bus.cla_c;
          // c_out is loaded on the way into FINISH so it is valid with done
          if (end_chain) c_q <= bus.cla_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.cla_a   = a_q;
  assign bus.cla_b   = b_q;
  assign bus.cla_y   = carry_q;
  assign bus.s_out   = s_q;
  assign bus.s_valid = s_vld_q;
  assign bus.c_out   = c_q;
endmodule

// File: tb/tb_cla_chain_sequencer.sv
// Self-checking bench for cla_chain_sequencer: directed scenarios plus
// randomized chained additions checked against a whole-number model.
module tb_cla_chain_sequencer;
  localparam int W  = 7;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   nchk = 0;
  int   nfail = 0;

  logic [W-1:0] wa [16];
  logic [W-1:0] wb [16];
  bit           wl [16];
  logic [W-1:0] sq [$];
  logic         dq [$];

  cla_chain_sequencer_if #(.WIDTH(W)) bus ();

  cla_chain_sequencer #(.WIDTH(W), .MAX_WORDS(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // external carry_look_ahead adder
  assign {bus.cla_c, bus.cla_s} = (W+1)'(bus.cla_a) + (W+1)'(bus.cla_b) + (W+1)'(bus.cla_y);

  always #5 clk = ~clk;

  // collect result words and done pulses away from the active edge
  always @(negedge clk) begin
    if (bus.s_valid === 1'b1) sq.push_back(bus.s_out);
    if (bus.done === 1'b1)    dq.push_back(bus.c_out);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one chained addition using wa/wb/wl[0..n-1]; checks every result word
  task automatic run_op(input int n, input bit cin, input int gap_max, input bit poke);
    int eff, t, g;
    longint a_sum, b_sum, s_sum;
    logic [W-1:0] exp_w;
    bit exp_c;
    eff = n;
    for (int i = 0; i < n; i++)
      if (wl[i] || i + 1 == MW) begin eff = i + 1; break; end
    a_sum = 0; b_sum = 0;
    for (int i = 0; i < eff; i++) begin
      a_sum += longint'(wa[i]) << (W * i);
      b_sum += longint'(wb[i]) << (W * i);
    end
    s_sum = a_sum + b_sum + longint'(cin);
    exp_c = s_sum[W * eff];
    sq.delete(); dq.delete();
    bus.start = 1'b1; bus.carry_in = cin;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < eff; i++) begin
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      bus.in_valid = 1'b0;
      bus.start = poke; bus.carry_in = poke ? !cin : cin;
      repeat (g) tick();
      bus.in_valid = 1'b1; bus.a_in = wa[i]; bus.b_in = wb[i]; bus.in_last = wl[i];
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 20) begin tick(); t++; end
      nchk++;
      if (t == 20) begin nfail++; $display("FAIL in_ready_timeout word %0d: in_ready=%b required 1", i, bus.in_ready); end
      tick();
      bus.in_valid = 1'b0; bus.start = 1'b0; bus.carry_in = cin;
      tick();
    end
    t = 0;
    while (dq.size() == 0 && t < 10) begin tick(); t++; end
    nchk++;
    if (dq.size() != 1) begin nfail++; $display("FAIL done_count: got %0d pulses required 1", dq.size()); end
    else begin
      nchk++;
      if (dq[0] !== exp_c) begin nfail++; $display("FAIL c_out: got %b required %b", dq[0], exp_c); end
    end
    nchk++;
    if (bus.busy !== 1'b0) begin nfail++; $display("FAIL busy_after_done: got %b required 0", bus.busy); end
    nchk++;
    if (sq.size() != eff) begin nfail++; $display("FAIL s_valid_count: got %0d required %0d", sq.size(), eff); end
    else
      for (int i = 0; i < eff; i++) begin
        exp_w = W'(s_sum >> (W * i));
        nchk++;
        if (sq[i] !== exp_w) begin nfail++; $display("FAIL s_out word %0d: got %0d required %0d", i, sq[i], exp_w); end
      end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    nchk++; if (bus.busy !== 1'b0)     begin nfail++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    nchk++; if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
    nchk++; if (bus.s_valid !== 1'b0)  begin nfail++; $display("FAIL rst_s_valid: got %b required 0", bus.s_valid); end
    nchk++; if (bus.done !== 1'b0)     begin nfail++; $display("FAIL rst_done: got %b required 0", bus.done); end
    nchk++; if (bus.s_out !== '0)      begin nfail++; $display("FAIL rst_s_out: got %0d required 0", bus.s_out); end
    nchk++; if (bus.c_out !== 1'b0)    begin nfail++; $display("FAIL rst_c_out: got %b required 0", bus.c_out); end
    nchk++; if (bus.cla_a !== '0 || bus.cla_b !== '0) begin nfail++; $display("FAIL rst_cla_ab: got %0d/%0d required 0/0", bus.cla_a, bus.cla_b); end
    nchk++; if (bus.cla_y !== 1'b0)    begin nfail++; $display("FAIL rst_cla_y: got %b required 0", bus.cla_y); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_two_words;
    wa[0] = 7'd127; wb[0] = 7'd1; wl[0] = 0;
    wa[1] = 7'd0;   wb[1] = 7'd0; wl[1] = 1;
    run_op(2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_single_word;
    wa[0] = 7'd127; wb[0] = 7'd127; wl[0] = 1;
    run_op(1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_max_words;
    for (int i = 0; i < 5; i++) begin wa[i] = 7'd127; wb[i] = 7'd0; wl[i] = 0; end
    run_op(5, 1'b1, 0, 1'b0);
    bus.in_valid = 1'b1; bus.a_in = 7'd127; bus.b_in = 7'd0; bus.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL fifth_word_ready: got %b required 0", bus.in_ready); end
      tick();
    end
    bus.in_valid = 1'b0;
    nchk++;
    if (sq.size() != MW || bus.busy !== 1'b0) begin nfail++; $display("FAIL fifth_word_taken: words=%0d busy=%b required %0d/0", sq.size(), bus.busy, MW); end
  endtask

  task automatic test_abort;
    sq.delete(); dq.delete();
    bus.start = 1'b1; bus.carry_in = 1'b0; tick(); bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.a_in = 7'd3; bus.b_in = 7'd4; bus.in_last = 1'b0; tick();
    bus.in_valid = 1'b0; tick();
    bus.in_valid = 1'b1; bus.a_in = 7'd5; bus.b_in = 7'd6; tick();
    bus.in_valid = 1'b0; bus.abort = 1'b1; tick();
    bus.abort = 1'b0;
    nchk++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL abort_busy: got %b required 0", bus.busy); end
    repeat (3) tick();
    nchk++; if (sq.size() != 1) begin nfail++; $display("FAIL abort_s_valid: got %0d words required 1", sq.size()); end
    nchk++; if (dq.size() != 0) begin nfail++; $display("FAIL abort_done: got %0d pulses required 0", dq.size()); end
    // abort together with start in IDLE must not start an operation
    bus.start = 1'b1; bus.abort = 1'b1; tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    nchk++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL abort_start_idle: busy=%b required 0", bus.busy); end
    wa[0] = 7'd100; wb[0] = 7'd50; wl[0] = 0;
    wa[1] = 7'd9;   wb[1] = 7'd1;  wl[1] = 1;
    run_op(2, 1'b0, 1, 1'b0);
  endtask

  task automatic test_reset_mid_op;
    bus.start = 1'b1; bus.carry_in = 1'b1; tick(); bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.a_in = 7'd5; bus.b_in = 7'd9; bus.in_last = 1'b0; tick();
    bus.in_valid = 1'b0; tick();
    nchk++; if (bus.s_out !== 7'd15) begin nfail++; $display("FAIL pre_reset_s_out: got %0d required 15", bus.s_out); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    sq.delete(); dq.delete();
    nchk++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.s_out !== '0 || bus.c_out !== 1'b0 ||
        bus.cla_a !== '0 || bus.cla_b !== '0 || bus.cla_y !== 1'b0)
      begin nfail++; $display("FAIL mid_reset_outputs: busy=%b rdy=%b s=%0d c=%b a=%0d b=%0d y=%b required all 0",
        bus.busy, bus.in_ready, bus.s_out, bus.c_out, bus.cla_a, bus.cla_b, bus.cla_y); end
    repeat (3) tick();
    nchk++; if (sq.size() != 0 || dq.size() != 0) begin nfail++; $display("FAIL mid_reset_pulses: s_valid=%0d done=%0d required 0/0", sq.size(), dq.size()); end
  endtask

  task automatic test_start_while_busy;
    wa[0] = 7'd127; wb[0] = 7'd0; wl[0] = 0;
    wa[1] = 7'd64;  wb[1] = 7'd63; wl[1] = 1;
    run_op(2, 1'b1, 2, 1'b1);
  endtask

  task automatic test_idle_wait;
    logic [W-1:0] s_hold;
    bus.start = 1'b1; bus.carry_in = 1'b0; tick(); bus.start = 1'b0;
    bus.in_valid = 1'b0;
    s_hold = bus.s_out;
    sq.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      nchk++;
      if (bus.in_ready !== 1'b1 || bus.s_out !== s_hold || sq.size() != 0)
        begin nfail++; $display("FAIL wait_in_hold cycle %0d: rdy=%b s=%0d words=%0d required 1/%0d/0", i, bus.in_ready, bus.s_out, sq.size(), s_hold); end
    end
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
  endtask

  task automatic test_random;
    int n;
    for (int k = 0; k < 30; k++) begin
      n = $urandom_range(MW + 1, 1);
      for (int i = 0; i < n; i++) begin
        wa[i] = W'($urandom); wb[i] = W'($urandom); wl[i] = ($urandom_range(3, 0) == 0);
      end
      if (n <= MW) wl[n-1] = 1;
      run_op(n, 1'($urandom), 2, 1'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.carry_in = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
    bus.a_in = '0; bus.b_in = '0; bus.in_last = 1'b0;
    test_reset();
    test_two_words();
    test_single_word();
    test_max_words();
    test_abort();
    test_reset_mid_op();
    test_start_while_busy();
    test_idle_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
